// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives it to the instruction memory
// and captures the returned word into the IF/ID register. It has run/idle
// control, a decode-side stall and a branch/jump redirect that flushes IF/ID.
module fetch_stage #(
  parameter int          MEM_BYTES = 128,
  parameter logic [15:0] RESET_PC  = 16'h0
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Run,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  input  logic [15:0] Instruction,
  output logic [15:0] PC,
  output logic [15:0] IF_PC,
  output logic [15:0] IF_Instr,
  output logic        IF_Valid,
  output logic        Misaligned
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

  // Keeps redirect addresses inside memory and halfword aligned.
  localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1) & 16'hFFFE;

  state_t      state, state_nx;
  logic        do_redirect, do_fetch, do_flush;
  logic [16:0] pc_inc;
  logic [15:0] pc_next;

  // Sequential PC; the extra bit catches the step past the top of memory.
  assign pc_inc  = {1'b0, PC} + 17'd2;
  assign pc_next = (pc_inc >= 17'(MEM_BYTES)) ? 16'h0 : pc_inc[15:0];

  // State register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state and datapath actions. Run=0 wins over everything, then a
  // redirect, then the per-state stall/fetch decision.
  always_comb begin
    state_nx    = state;
    do_redirect = 1'b0;
    do_fetch    = 1'b0;
    do_flush    = 1'b0;
    if (!Run) begin
      state_nx = IDLE;
      do_flush = 1'b1;
    end else if (BranchTaken) begin
      state_nx    = FETCH;
      do_redirect = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nx = FETCH;
          do_flush = 1'b1;
        end
        FETCH: begin
          if (Stall) state_nx = STALL;
          else       do_fetch = 1'b1;
        end
        STALL: begin
          if (!Stall) begin
            state_nx = FETCH;
            do_fetch = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // PC, IF/ID register and sticky misalignment flag. A redirect flushes IF/ID
  // but keeps the old IF_PC/IF_Instr contents; a stall simply holds everything.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      PC         <= RESET_PC;
      IF_PC      <= 16'h0;
      IF_Instr   <= 16'h0;
      IF_Valid   <= 1'b0;
      Misaligned <= 1'b0;
    end else if (do_redirect) begin
      PC       <= BranchTarget & ADDR_MASK;
      IF_Valid <= 1'b0;
      if (BranchTarget[0]) Misaligned <= 1'b1;
    end else if (do_flush) begin
      IF_Valid <= 1'b0;
    end else if (do_fetch) begin
      IF_Instr <= Instruction;
      IF_PC    <= PC;
      IF_Valid <= 1'b1;
      PC       <= pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table covering the main scenarios,
// a hand sequence for asynchronous reset mid-stall, then randomized traffic
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int MEMB = 128;

  logic        Clock, ResetN, Run, Stall, BranchTaken;
  logic [15:0] BranchTarget, Instruction, PC, IF_PC, IF_Instr;
  logic        IF_Valid, Misaligned;

  logic [7:0]  mem [MEMB];
  int          n_chk, n_fail;

  // Behavioural model state.
  logic [15:0] m_pc, m_ifpc, m_instr;
  logic        m_v, m_mis, m_armed;

  typedef struct {
    logic        run, stall, br;
    logic [15:0] tgt;
    logic [15:0] pc, ifpc, instr;
    logic        v, mis;
  } vec_t;

  vec_t tbl [20];

  fetch_stage #(.MEM_BYTES(MEMB), .RESET_PC(16'h0)) dut (
    .Clock(Clock), .ResetN(ResetN), .Run(Run), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Instruction(Instruction), .PC(PC), .IF_PC(IF_PC), .IF_Instr(IF_Instr),
    .IF_Valid(IF_Valid), .Misaligned(Misaligned)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory model: combinational byte-pair read at the DUT's PC.
  always_comb begin
    logic [6:0] a;
    a = PC[6:0];
    Instruction = {mem[a], mem[a + 7'd1]};
  end

  function automatic logic [15:0] word_at(logic [15:0] a);
    int i;
    i = int'(a) % MEMB;
    return {mem[i], mem[(i + 1) % MEMB]};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [15:0] pc, logic [15:0] ifpc,
                         logic [15:0] instr, logic v, logic mis);
    chk({tag, " PC"}, PC, pc);
    chk({tag, " IF_PC"}, IF_PC, ifpc);
    chk({tag, " IF_Instr"}, IF_Instr, instr);
    chk({tag, " IF_Valid"}, {15'h0, IF_Valid}, {15'h0, v});
    chk({tag, " Misaligned"}, {15'h0, Misaligned}, {15'h0, mis});
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Run = 0; Stall = 0; BranchTaken = 0; BranchTarget = 16'h0;
    ResetN = 0;
    #7;
    ResetN = 1;
    m_pc = 16'h0; m_ifpc = 16'h0; m_instr = 16'h0;
    m_v = 0; m_mis = 0; m_armed = 0;
  endtask

  // One clock edge of the fetch rules, in priority order.
  task automatic model_step(logic run, logic stall, logic br, logic [15:0] tgt);
    if (!run) begin
      m_armed = 0;
      m_v     = 0;
    end else if (br) begin
      m_pc    = 16'(int'(tgt) % MEMB) & 16'hFFFE;
      m_v     = 0;
      m_mis   = m_mis | tgt[0];
      m_armed = 1;
    end else if (!m_armed) begin
      m_armed = 1;
      m_v     = 0;
    end else if (!stall) begin
      m_instr = word_at(m_pc);
      m_ifpc  = m_pc;
      m_v     = 1;
      m_pc    = 16'((int'(m_pc) + 2) % MEMB);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;

    // Known memory image: byte i holds i, with a few marked words.
    for (int i = 0; i < MEMB; i++) mem[i] = 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h22;
    mem[4] = 8'h33; mem[5] = 8'h33;
    mem[8'h40] = 8'hAB; mem[8'h41] = 8'hCD;
    mem[8'h12] = 8'h5A; mem[8'h13] = 8'h5B;
    mem[8'h7E] = 8'hE7; mem[8'h7F] = 8'h7E;

    //          run stall br  tgt        pc       ifpc     instr    v  mis
    tbl[0]  = '{1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0}; // IDLE->FETCH
    tbl[1]  = '{1, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h1111, 1, 0};
    tbl[2]  = '{1, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h2222, 1, 0};
    tbl[3]  = '{1, 1, 0, 16'h0000, 16'h0004, 16'h0002, 16'h2222, 1, 0}; // stall x3
    tbl[4]  = '{1, 1, 0, 16'h0000, 16'h0004, 16'h0002, 16'h2222, 1, 0};
    tbl[5]  = '{1, 1, 0, 16'h0000, 16'h0004, 16'h0002, 16'h2222, 1, 0};
    tbl[6]  = '{1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h3333, 1, 0};
    tbl[7]  = '{1, 1, 1, 16'h0040, 16'h0040, 16'h0004, 16'h3333, 0, 0}; // redirect over stall
    tbl[8]  = '{1, 0, 0, 16'h0000, 16'h0042, 16'h0040, 16'hABCD, 1, 0};
    tbl[9]  = '{1, 0, 1, 16'h0013, 16'h0012, 16'h0040, 16'hABCD, 0, 1}; // odd target
    tbl[10] = '{1, 0, 0, 16'h0000, 16'h0014, 16'h0012, 16'h5A5B, 1, 1};
    tbl[11] = '{1, 0, 1, 16'h007E, 16'h007E, 16'h0012, 16'h5A5B, 0, 1};
    tbl[12] = '{1, 0, 0, 16'h0000, 16'h0000, 16'h007E, 16'hE77E, 1, 1}; // wrap
    tbl[13] = '{1, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h1111, 1, 1};
    tbl[14] = '{0, 0, 1, 16'h0020, 16'h0002, 16'h0000, 16'h1111, 0, 1}; // branch ignored
    tbl[15] = '{0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h1111, 0, 1};
    tbl[16] = '{1, 1, 0, 16'h0000, 16'h0002, 16'h0000, 16'h1111, 0, 1}; // IDLE: no fetch
    tbl[17] = '{1, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h2222, 1, 1};
    tbl[18] = '{1, 0, 1, 16'h0105, 16'h0004, 16'h0002, 16'h2222, 0, 1}; // masked target
    tbl[19] = '{1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h3333, 1, 1};

    do_reset();
    #1;
    chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < 20; i++) begin
      Run = tbl[i].run; Stall = tbl[i].stall;
      BranchTaken = tbl[i].br; BranchTarget = tbl[i].tgt;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ifpc, tbl[i].instr,
              tbl[i].v, tbl[i].mis);
    end

    // Asynchronous reset in the middle of a stall, then idle after release.
    Run = 1; Stall = 1; BranchTaken = 0;
    tick();
    #2;
    ResetN = 0;
    #1;
    chk_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 0, 0);
    @(negedge Clock);
    ResetN = 1; Run = 0; Stall = 0;
    tick();
    tick();
    chk_all("post_rst_idle", 16'h0000, 16'h0000, 16'h0000, 0, 0);
    Run = 1;
    tick();
    tick();
    chk_all("post_rst_first", 16'h0002, 16'h0000, 16'h1111, 1, 0);

    // Randomized traffic against the model.
    @(negedge Clock);
    do_reset();
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 2000; i++) begin
      Run          = ($urandom_range(0, 9) != 0);
      Stall        = ($urandom_range(0, 3) == 0);
      BranchTaken  = ($urandom_range(0, 9) == 0);
      BranchTarget = 16'($urandom);
      model_step(Run, Stall, BranchTaken, BranchTarget);
      tick();
      if (i % 50 == 0)
        chk_all($sformatf("rnd%0d", i), m_pc, m_ifpc, m_instr, m_v, m_mis);
      else begin
        chk($sformatf("rnd%0d PC", i), PC, m_pc);
        chk($sformatf("rnd%0d IF_Valid", i), {15'h0, IF_Valid}, {15'h0, m_v});
        if (m_v) chk($sformatf("rnd%0d IF_Instr", i), IF_Instr, m_instr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
